// File: rtl/ysyx_25040109_lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 access-size codes and FSM states.
package ysyx_25040109_lsu_pkg;

   localparam logic [2:0] LSU_B  = 3'b000;
   localparam logic [2:0] LSU_H  = 3'b001;
   localparam logic [2:0] LSU_W  = 3'b010;
   localparam logic [2:0] LSU_BU = 3'b100;
   localparam logic [2:0] LSU_HU = 3'b101;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ADDR,
      ST_RD_DATA,
      ST_WR,
      ST_RESP
   } lsu_state_e;

endpackage

// File: rtl/ysyx_25040109_lsu_align.sv
// Combinational lane logic: request legality check, store byte mask, load lane extract/extend.
module ysyx_25040109_lsu_align
   import ysyx_25040109_lsu_pkg::*;
(
   input  logic [2:0]  chk_funct3,
   input  logic [1:0]  chk_off,
   input  logic        chk_wen,
   output logic        chk_err,
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] rword,
   output logic [3:0]  wmask,
   output logic [31:0] rdata_ext
);

   logic [31:0] shifted;

   // Unsigned sizes exist only for loads, so BU/HU on a store is illegal.
   always_comb begin
      chk_err = 1'b0;
      case (chk_funct3)
         LSU_B:   chk_err = 1'b0;
         LSU_H:   chk_err = chk_off[0];
         LSU_W:   chk_err = (chk_off != 2'b00);
         LSU_BU:  chk_err = chk_wen;
         LSU_HU:  chk_err = chk_wen | chk_off[0];
         default: chk_err = 1'b1;
      endcase
   end

   always_comb begin
      wmask = '0;
      case (funct3)
         LSU_B, LSU_BU: wmask = 4'b0001 << off;
         LSU_H, LSU_HU: wmask = 4'b0011 << off;
         LSU_W:         wmask = 4'b1111;
         default:       wmask = '0;
      endcase
   end

   always_comb begin
      shifted   = rword >> {off, 3'b000};
      rdata_ext = '0;
      case (funct3)
         LSU_B:   rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
         LSU_H:   rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
         LSU_W:   rdata_ext = shifted;
         LSU_BU:  rdata_ext = {24'h0, shifted[7:0]};
         LSU_HU:  rdata_ext = {16'h0, shifted[15:0]};
         default: rdata_ext = '0;
      endcase
   end

endmodule

// File: rtl/ysyx_25040109_lsu.sv
// Load/store unit: one EXU request at a time onto the dmem AR/R and AW/W handshakes,
// returning exactly one response per accepted request.
module ysyx_25040109_lsu
   import ysyx_25040109_lsu_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wen,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [2:0]        req_funct3,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] dmem_araddr,
   output logic              dmem_arvalid,
   input  logic              dmem_arready,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_rvalid,
   output logic              dmem_rready,
   output logic [ADDR_W-1:0] dmem_awaddr,
   output logic              dmem_awvalid,
   input  logic              dmem_awready,
   output logic [DATA_W-1:0] dmem_wdata,
   output logic [3:0]        dmem_wmask,
   output logic              dmem_wen,
   output logic              dmem_wvalid,
   input  logic              dmem_wready
);

   lsu_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [2:0]        funct3_q, funct3_d;
   logic              wen_q, wen_d;
   logic              aw_done_q, aw_done_d;
   logic              w_done_q, w_done_d;
   logic              err_q, err_d;

   logic              chk_err;
   logic [3:0]        lane_mask;
   logic [DATA_W-1:0] load_ext;
   logic              aw_fire, w_fire;

   ysyx_25040109_lsu_align u_align (
      .chk_funct3 (req_funct3),
      .chk_off    (req_addr[1:0]),
      .chk_wen    (req_wen),
      .chk_err    (chk_err),
      .funct3     (funct3_q),
      .off        (addr_q[1:0]),
      .rword      (dmem_rdata),
      .wmask      (lane_mask),
      .rdata_ext  (load_ext)
   );

   // rready stays high in IDLE so a read left in flight by a reset is drained and dropped.
   assign req_ready    = (state_q == ST_IDLE);
   assign resp_valid   = (state_q == ST_RESP);
   assign resp_rdata   = rdata_q;
   assign resp_err     = err_q;
   assign dmem_araddr  = {addr_q[ADDR_W-1:2], 2'b00};
   assign dmem_arvalid = (state_q == ST_RD_ADDR);
   assign dmem_rready  = (state_q == ST_IDLE) || (state_q == ST_RD_DATA);
   assign dmem_awaddr  = addr_q;
   assign dmem_awvalid = (state_q == ST_WR) && !aw_done_q;
   assign dmem_wvalid  = (state_q == ST_WR) && !w_done_q;
   assign dmem_wen     = dmem_wvalid;
   assign dmem_wdata   = wdata_q;
   assign dmem_wmask   = wen_q ? lane_mask : '0;

   assign aw_fire = dmem_awvalid && dmem_awready;
   assign w_fire  = dmem_wvalid && dmem_wready;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      funct3_d  = funct3_q;
      wen_d     = wen_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      err_d     = err_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               addr_d    = req_addr;
               wdata_d   = req_wdata;
               funct3_d  = req_funct3;
               wen_d     = req_wen;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               rdata_d   = '0;
               err_d     = chk_err;
               if (chk_err)      state_d = ST_RESP;
               else if (req_wen) state_d = ST_WR;
               else              state_d = ST_RD_ADDR;
            end
         end
         ST_RD_ADDR: begin
            if (dmem_arready) state_d = ST_RD_DATA;
         end
         ST_RD_DATA: begin
            if (dmem_rvalid) begin
               rdata_d = load_ext;
               state_d = ST_RESP;
            end
         end
         ST_WR: begin
            aw_done_d = aw_done_q | aw_fire;
            w_done_d  = w_done_q | w_fire;
            if (aw_done_d && w_done_d) state_d = ST_RESP;
         end
         ST_RESP: begin
            if (resp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         funct3_q  <= '0;
         wen_q     <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         funct3_q  <= funct3_d;
         wen_q     <= wen_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_ysyx_25040109_lsu.sv
// Directed bench for ysyx_25040109_lsu against a small single-word dmem responder.
module tb_ysyx_25040109_lsu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_wen = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [2:0]  req_funct3 = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] dmem_araddr;
   logic        dmem_arvalid;
   logic        dmem_arready;
   logic [31:0] dmem_rdata;
   logic        dmem_rvalid;
   logic        dmem_rready;
   logic [31:0] dmem_awaddr;
   logic        dmem_awvalid;
   logic        dmem_awready;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wmask;
   logic        dmem_wen;
   logic        dmem_wvalid;
   logic        dmem_wready;

   always #5 clk = ~clk;

   ysyx_25040109_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_wen      (req_wen),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_funct3   (req_funct3),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .dmem_araddr  (dmem_araddr),
      .dmem_arvalid (dmem_arvalid),
      .dmem_arready (dmem_arready),
      .dmem_rdata   (dmem_rdata),
      .dmem_rvalid  (dmem_rvalid),
      .dmem_rready  (dmem_rready),
      .dmem_awaddr  (dmem_awaddr),
      .dmem_awvalid (dmem_awvalid),
      .dmem_awready (dmem_awready),
      .dmem_wdata   (dmem_wdata),
      .dmem_wmask   (dmem_wmask),
      .dmem_wen     (dmem_wen),
      .dmem_wvalid  (dmem_wvalid),
      .dmem_wready  (dmem_wready)
   );

   // dmem responder: ignores rst_n so a read in flight across a reset still returns.
   logic [31:0] mem_word = '0;
   int unsigned rd_delay = 0;
   int unsigned aw_delay = 0;
   int unsigned rd_cnt = 0;
   logic        rd_pend = 1'b0;
   logic        rvalid_r = 1'b0;
   int unsigned aw_wait = 0;
   logic        aw_seen = 1'b0;
   int unsigned ar_fires = 0, aw_fires = 0, w_fires = 0, resp_cnt = 0;
   int unsigned arv_seen = 0, awv_seen = 0;
   logic [31:0] last_araddr = '0, last_awaddr = '0, last_wdata = '0, last_rdata = '0;
   logic [3:0]  last_wmask = '0;
   logic        last_err = 1'b0;

   assign dmem_arready = 1'b1;
   assign dmem_rdata   = mem_word;
   assign dmem_rvalid  = rvalid_r;
   assign dmem_awready = dmem_awvalid && (aw_wait >= aw_delay);
   assign dmem_wready  = aw_seen || (dmem_awvalid && dmem_awready);

   always @(posedge clk) begin
      if (dmem_arvalid) arv_seen <= arv_seen + 1;
      if (dmem_awvalid) awv_seen <= awv_seen + 1;
      if (dmem_arvalid && dmem_arready) begin
         ar_fires    <= ar_fires + 1;
         last_araddr <= dmem_araddr;
         rd_pend     <= 1'b1;
         rd_cnt      <= rd_delay;
      end else if (rd_pend) begin
         if (rd_cnt == 0) begin
            rvalid_r <= 1'b1;
            rd_pend  <= 1'b0;
         end else begin
            rd_cnt <= rd_cnt - 1;
         end
      end
      if (rvalid_r && dmem_rready) rvalid_r <= 1'b0;
      if (dmem_awvalid && !dmem_awready) aw_wait <= aw_wait + 1;
      if (dmem_awvalid && dmem_awready) begin
         aw_fires    <= aw_fires + 1;
         last_awaddr <= dmem_awaddr;
         aw_seen     <= 1'b1;
         aw_wait     <= 0;
      end
      if (dmem_wvalid && dmem_wready) begin
         w_fires    <= w_fires + 1;
         last_wdata <= dmem_wdata;
         last_wmask <= dmem_wmask;
         aw_seen    <= 1'b0;
      end
      if (resp_valid && resp_ready) begin
         resp_cnt   <= resp_cnt + 1;
         last_rdata <= resp_rdata;
         last_err   <= resp_err;
      end
   end

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic do_req(input string tag, input logic wen, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [2:0] f3);
      bit rdy = 1'b0;
      for (int i = 0; i < 20 && !rdy; i++) begin
         @(negedge clk);
         rdy = req_ready;
      end
      check({tag, "_req_ready"}, {31'h0, rdy}, 32'h1);
      req_wen    = wen;
      req_addr   = addr;
      req_wdata  = wd;
      req_funct3 = f3;
      req_valid  = 1'b1;
      @(negedge clk);
      req_valid  = 1'b0;
   endtask

   task automatic wait_resp(input string tag, input int unsigned max_cyc);
      int unsigned start = resp_cnt;
      bit got = 1'b0;
      for (int unsigned i = 0; i < max_cyc && !got; i++) begin
         if (resp_cnt != start) got = 1'b1;
         else @(negedge clk);
      end
      if (!got && resp_cnt != start) got = 1'b1;
      check({tag, "_resp"}, {31'h0, got}, 32'h1);
   endtask

   initial begin
      int unsigned r0, a0, w0, ar0, aw0;
      bit saw_resp;

      repeat (3) @(negedge clk);
      check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
      check("rst_arvalid", {31'h0, dmem_arvalid}, 32'h0);
      check("rst_awvalid", {31'h0, dmem_awvalid}, 32'h0);
      check("rst_wvalid", {31'h0, dmem_wvalid}, 32'h0);
      check("rst_rdata", resp_rdata, 32'h0);
      check("rst_err", {31'h0, resp_err}, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_req_ready", {31'h0, req_ready}, 32'h1);

      // Loads from word 0x80FF1234
      mem_word = 32'h80FF_1234;
      do_req("lb", 1'b0, 32'h8000_0003, '0, 3'b000);
      check("lb_arvalid_n1", {31'h0, dmem_arvalid}, 32'h1);
      check("lb_araddr_live", dmem_araddr, 32'h8000_0000);
      wait_resp("lb", 20);
      check("lb_araddr", last_araddr, 32'h8000_0000);
      check("lb_rdata", last_rdata, 32'hFFFF_FF80);
      check("lb_err", {31'h0, last_err}, 32'h0);

      do_req("lhu", 1'b0, 32'h8000_0002, '0, 3'b101);
      wait_resp("lhu", 20);
      check("lhu_rdata", last_rdata, 32'h0000_80FF);
      do_req("lh", 1'b0, 32'h8000_0002, '0, 3'b001);
      wait_resp("lh", 20);
      check("lh_rdata", last_rdata, 32'hFFFF_80FF);
      do_req("lbu", 1'b0, 32'h8000_0001, '0, 3'b100);
      wait_resp("lbu", 20);
      check("lbu_rdata", last_rdata, 32'h0000_0012);

      // SB with response back-pressure
      r0 = resp_cnt; w0 = w_fires;
      resp_ready = 1'b0;
      do_req("sb", 1'b1, 32'h8000_0001, 32'h0000_00AB, 3'b000);
      saw_resp = 1'b0;
      for (int i = 0; i < 20 && !saw_resp; i++) begin
         if (resp_valid) saw_resp = 1'b1;
         else @(negedge clk);
      end
      repeat (2) @(negedge clk);
      check("sb_resp_hold", {31'h0, resp_valid}, 32'h1);
      check("sb_resp_hold_rdata", resp_rdata, 32'h0);
      check("sb_no_early_resp", resp_cnt - r0, 32'd0);
      resp_ready = 1'b1;
      @(negedge clk);
      check("sb_awaddr", last_awaddr, 32'h8000_0001);
      check("sb_wmask", {28'h0, last_wmask}, 32'h2);
      check("sb_wdata", last_wdata, 32'h0000_00AB);
      check("sb_rdata", last_rdata, 32'h0);
      check("sb_resp_cnt", resp_cnt - r0, 32'd1);
      check("sb_w_cnt", w_fires - w0, 32'd1);

      do_req("sh", 1'b1, 32'h8000_0002, 32'h0000_1234, 3'b001);
      wait_resp("sh", 20);
      check("sh_wmask", {28'h0, last_wmask}, 32'hC);

      // SW with awready held off for 3 cycles
      aw_delay = 3;
      r0 = resp_cnt; a0 = aw_fires; w0 = w_fires;
      do_req("sw", 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 3'b010);
      check("sw_awvalid", {31'h0, dmem_awvalid}, 32'h1);
      check("sw_wvalid", {31'h0, dmem_wvalid}, 32'h1);
      @(negedge clk);
      @(negedge clk);
      check("sw_wvalid_held", {31'h0, dmem_wvalid}, 32'h1);
      wait_resp("sw", 20);
      repeat (3) @(negedge clk);
      check("sw_aw_cnt", aw_fires - a0, 32'd1);
      check("sw_w_cnt", w_fires - w0, 32'd1);
      check("sw_resp_cnt", resp_cnt - r0, 32'd1);
      check("sw_wmask", {28'h0, last_wmask}, 32'hF);
      check("sw_wdata", last_wdata, 32'hDEAD_BEEF);
      check("sw_awaddr", last_awaddr, 32'h8000_0004);
      aw_delay = 0;

      // Rejected requests never reach dmem
      ar0 = arv_seen; aw0 = awv_seen;
      do_req("lw_mis", 1'b0, 32'h8000_0002, '0, 3'b010);
      wait_resp("lw_mis", 2);
      check("lw_mis_err", {31'h0, last_err}, 32'h1);
      check("lw_mis_rdata", last_rdata, 32'h0);
      do_req("sh_mis", 1'b1, 32'h8000_0001, 32'h5555_5555, 3'b001);
      wait_resp("sh_mis", 2);
      check("sh_mis_err", {31'h0, last_err}, 32'h1);
      do_req("ld_f3_011", 1'b0, 32'h8000_0000, '0, 3'b011);
      wait_resp("ld_f3_011", 2);
      check("ld_f3_011_err", {31'h0, last_err}, 32'h1);
      do_req("st_f3_100", 1'b1, 32'h8000_0000, '0, 3'b100);
      wait_resp("st_f3_100", 2);
      check("st_f3_100_err", {31'h0, last_err}, 32'h1);
      @(negedge clk);
      check("err_no_arvalid", arv_seen - ar0, 32'd0);
      check("err_no_awvalid", awv_seen - aw0, 32'd0);

      // Reset in RD_DATA with read data arriving afterwards
      rd_delay = 4;
      r0 = resp_cnt;
      do_req("rst_mid", 1'b0, 32'h8000_0000, '0, 3'b010);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_mid_arvalid", {31'h0, dmem_arvalid}, 32'h0);
      check("rst_mid_resp_valid", {31'h0, resp_valid}, 32'h0);
      check("rst_mid_req_ready", {31'h0, req_ready}, 32'h1);
      @(negedge clk);
      rst_n = 1'b1;
      saw_resp = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (resp_valid) saw_resp = 1'b1;
      end
      check("rst_mid_no_resp", {31'h0, saw_resp}, 32'h0);
      check("rst_mid_resp_cnt", resp_cnt - r0, 32'd0);
      check("rst_mid_drained", {31'h0, dmem_rvalid}, 32'h0);
      rd_delay = 0;
      mem_word = 32'h1357_9BDF;
      do_req("lw_after", 1'b0, 32'h8000_0000, '0, 3'b010);
      wait_resp("lw_after", 20);
      check("lw_after_araddr", last_araddr, 32'h8000_0000);
      check("lw_after_rdata", last_rdata, 32'h1357_9BDF);
      check("lw_after_err", {31'h0, last_err}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
